uart_tx: RTL and testbench

UART transmitter that serialises parallel words onto a single `tx` line as a start bit, data bits (LSB first), an optional parity bit and stop bits. It sits between a word producer, which uses a ready/valid handshake, and the UART pin. An external generator supplies a `baud_tick` enable at BAUD_RATE × OVERSAMPLE. A one-word holding register allows frames to be sent back-to-back with no idle gap.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_tx.sv | 173 +++++++++++++++++
 tb/tb_uart_tx.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART types: parity mode selection and transmitter FSM states.
package UART_pkg;

    typedef enum logic [1:0] {
        PARITY_NONE = 2'd0,
        PARITY_EVEN = 2'd1,
        PARITY_ODD  = 2'd2
    } parity_t;

    // Three-bit encoding leaves spare codes; the FSM treats them as illegal.
    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_t;

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional parity, stop bits.
// A one-word holding register lets consecutive frames run with no idle gap.
module uart_tx
    import UART_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PARITY     = 1,
    parameter int OVERSAMPLE = 16,
    parameter int STOP_BITS  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  baud_tick,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_valid,
    output logic                  tx_ready,
    output logic                  tx,
    output logic                  busy
);

    localparam int TICK_W = $clog2(OVERSAMPLE * STOP_BITS) + 1;
    localparam int IDX_W  = $clog2(DATA_WIDTH) + 1;

    localparam logic [TICK_W-1:0] BIT_END  = TICK_W'(OVERSAMPLE);
    localparam logic [TICK_W-1:0] STOP_END = TICK_W'(OVERSAMPLE * STOP_BITS);
    localparam logic [TICK_W-1:0] TICK_ONE = TICK_W'(1);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DATA_WIDTH - 1);
    localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);
    localparam parity_t           PAR_MODE = parity_t'(PARITY);

    tx_state_t             state_reg, state_next;
    logic [TICK_W-1:0]     tick_cnt_reg, tick_cnt_next;
    logic [IDX_W-1:0]      bit_idx_reg, bit_idx_next;
    logic [DATA_WIDTH-1:0] shift_reg, shift_next;
    logic [DATA_WIDTH-1:0] hold_reg, hold_next;
    logic                  hold_full_reg, hold_full_next;
    logic                  par_reg, par_next;
    logic                  tx_reg, tx_next;
    logic                  load;

    function automatic logic parity_of(input logic [DATA_WIDTH-1:0] d);
        return (PAR_MODE == PARITY_ODD) ? ~^d : ^d;
    endfunction

    always_comb begin
        state_next     = state_reg;
        tick_cnt_next  = tick_cnt_reg;
        bit_idx_next   = bit_idx_reg;
        shift_next     = shift_reg;
        hold_next      = hold_reg;
        hold_full_next = hold_full_reg;
        par_next       = par_reg;
        tx_next        = tx_reg;
        load           = 1'b0;

        case (state_reg)
            TX_IDLE: begin
                if (baud_tick) begin
                    tx_next = 1'b1;
                    load    = hold_full_reg;
                end
            end
            TX_START: begin
                if (baud_tick) begin
                    tick_cnt_next = tick_cnt_reg + TICK_ONE;
                    if (tick_cnt_reg == BIT_END) begin
                        tx_next       = shift_reg[0];
                        bit_idx_next  = '0;
                        tick_cnt_next = TICK_ONE;
                        state_next    = TX_DATA;
                    end
                end
            end
            TX_DATA: begin
                if (baud_tick) begin
                    tick_cnt_next = tick_cnt_reg + TICK_ONE;
                    if (tick_cnt_reg == BIT_END) begin
                        tick_cnt_next = TICK_ONE;
                        if (bit_idx_reg == LAST_IDX) begin
                            bit_idx_next = '0;
                            if (PAR_MODE != PARITY_NONE) begin
                                tx_next    = par_reg;
                                state_next = TX_PARITY;
                            end else begin
                                tx_next    = 1'b1;
                                state_next = TX_STOP;
                            end
                        end else begin
                            // Bit 0 always sits at the bottom of the shifter.
                            shift_next   = shift_reg >> 1;
                            tx_next      = shift_reg[1];
                            bit_idx_next = bit_idx_reg + IDX_ONE;
                        end
                    end
                end
            end
            TX_PARITY: begin
                if (baud_tick) begin
                    tick_cnt_next = tick_cnt_reg + TICK_ONE;
                    if (tick_cnt_reg == BIT_END) begin
                        tick_cnt_next = TICK_ONE;
                        tx_next       = 1'b1;
                        state_next    = TX_STOP;
                    end
                end
            end
            TX_STOP: begin
                if (baud_tick) begin
                    tick_cnt_next = tick_cnt_reg + TICK_ONE;
                    if (tick_cnt_reg == STOP_END) begin
                        if (hold_full_reg) begin
                            load = 1'b1;
                        end else begin
                            tick_cnt_next = '0;
                            tx_next       = 1'b1;
                            state_next    = TX_IDLE;
                        end
                    end
                end
            end
            default: begin
                state_next    = TX_IDLE;
                tick_cnt_next = '0;
                bit_idx_next  = '0;
                tx_next       = 1'b1;
            end
        endcase

        // Holding register moves into the shifter and the start bit begins.
        if (load) begin
            shift_next     = hold_reg;
            par_next       = parity_of(hold_reg);
            hold_full_next = 1'b0;
            tx_next        = 1'b0;
            tick_cnt_next  = TICK_ONE;
            bit_idx_next   = '0;
            state_next     = TX_START;
        end

        // Accept after the transfer so a same-edge accept leaves the register full.
        if (data_valid && !hold_full_reg) begin
            hold_next      = data_in;
            hold_full_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= TX_IDLE;
            tick_cnt_reg  <= '0;
            bit_idx_reg   <= '0;
            shift_reg     <= '0;
            hold_reg      <= '0;
            hold_full_reg <= 1'b0;
            par_reg       <= 1'b0;
            tx_reg        <= 1'b1;
        end else begin
            state_reg     <= state_next;
            tick_cnt_reg  <= tick_cnt_next;
            bit_idx_reg   <= bit_idx_next;
            shift_reg     <= shift_next;
            hold_reg      <= hold_next;
            hold_full_reg <= hold_full_next;
            par_reg       <= par_next;
            tx_reg        <= tx_next;
        end
    end

    assign tx       = tx_reg;
    assign tx_ready = ~hold_full_reg;
    assign busy     = (state_reg != TX_IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: three parameterisations checked bit-slot by bit-slot.
module tb_uart_tx;

    localparam int OS    = 16;
    localparam int LIMIT = 3000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       baud_tick = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [2:0] dv = 3'b000;
    logic [2:0] tx_v, ready_v, busy_v;
    int         div = 0;
    int         n_checks = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    // One baud tick every third clock, changed away from the active edge.
    always @(negedge clk) begin
        baud_tick = (div == 2);
        div = (div == 2) ? 0 : div + 1;
    end

    uart_tx #(.DATA_WIDTH(8), .PARITY(1), .OVERSAMPLE(OS), .STOP_BITS(1)) dut_even (
        .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .data_in(data_in),
        .data_valid(dv[0]), .tx_ready(ready_v[0]), .tx(tx_v[0]), .busy(busy_v[0]));

    uart_tx #(.DATA_WIDTH(8), .PARITY(2), .OVERSAMPLE(OS), .STOP_BITS(2)) dut_odd2 (
        .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .data_in(data_in),
        .data_valid(dv[1]), .tx_ready(ready_v[1]), .tx(tx_v[1]), .busy(busy_v[1]));

    uart_tx #(.DATA_WIDTH(8), .PARITY(0), .OVERSAMPLE(OS), .STOP_BITS(1)) dut_none (
        .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .data_in(data_in),
        .data_valid(dv[2]), .tx_ready(ready_v[2]), .tx(tx_v[2]), .busy(busy_v[2]));

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_tick();
        do @(posedge clk); while (!baud_tick);
        @(negedge clk);
        #1;
    endtask

    // Present a word and hold it until accepted; keep leaves data_valid high.
    task automatic send(input int which, input logic [7:0] w, input bit keep);
        int n = 0;
        data_in = w;
        dv[which] = 1'b1;
        while (!ready_v[which] && n < LIMIT) begin
            @(negedge clk);
            #1;
            n++;
        end
        check_val($sformatf("send_timeout_%0h", w), 32'(n >= LIMIT), 32'd0);
        @(posedge clk);
        @(negedge clk);
        #1;
        if (!keep) dv[which] = 1'b0;
        $display("dut%0d accepted word %02h", which, w);
    endtask

    function automatic logic slot_level(input logic [7:0] w, input bit has_par,
                                        input logic par, input int s);
        if (s == 0) return 1'b0;
        if (s <= 8) return w[s-1];
        if (s == 9 && has_par) return par;
        return 1'b1;
    endfunction

    // Each bit slot must hold its level for all OS ticks; the tick after the
    // frame is either the next start bit or idle.
    task automatic check_frame(input int which, input string tag, input logic [7:0] w,
                               input bit has_par, input logic par, input int nstop,
                               input bit wait_start, input bit b2b, input int lat_exp);
        int   nslots = 1 + 8 + (has_par ? 1 : 0) + nstop;
        int   n = 0;
        logic busy_min = 1'b1;
        logic exp_l, obs_l;
        if (wait_start) begin
            while (tx_v[which] !== 1'b0 && n < LIMIT) begin
                next_tick();
                n++;
            end
            check_val({tag, "_start_timeout"}, 32'(n >= LIMIT), 32'd0);
            if (lat_exp > 0) check_val({tag, "_latency"}, 32'(n), 32'(lat_exp));
        end
        for (int s = 0; s < nslots; s++) begin
            exp_l = slot_level(w, has_par, par, s);
            obs_l = exp_l;
            for (int k = 0; k < OS; k++) begin
                if (s != 0 || k != 0) next_tick();
                if (tx_v[which] !== exp_l) obs_l = tx_v[which];
                busy_min = busy_min & busy_v[which];
            end
            check_val($sformatf("%s_slot%0d", tag, s), 32'(obs_l), 32'(exp_l));
        end
        check_val({tag, "_busy"}, 32'(busy_min), 32'd1);
        next_tick();
        if (b2b) begin
            check_val({tag, "_b2b_start"}, 32'(tx_v[which]), 32'd0);
            check_val({tag, "_b2b_busy"}, 32'(busy_v[which]), 32'd1);
        end else begin
            check_val({tag, "_end_tx"}, 32'(tx_v[which]), 32'd1);
            check_val({tag, "_end_busy"}, 32'(busy_v[which]), 32'd0);
            check_val({tag, "_end_ready"}, 32'(ready_v[which]), 32'd1);
        end
        $display("dut%0d frame %s word %02h checked", which, tag, w);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) @(negedge clk);
        #1;
        check_val("rst_tx", 32'(tx_v), 32'h7);
        check_val("rst_ready", 32'(ready_v), 32'h7);
        check_val("rst_busy", 32'(busy_v), 32'h0);
        rst_n = 1'b1;
        repeat (2) next_tick();

        // 0x55 even parity: 4 ones -> parity 0
        fork
            send(0, 8'h55, 1'b0);
            check_frame(0, "even55", 8'h55, 1'b1, 1'b0, 1, 1'b1, 1'b0, 1);
        join
        next_tick();

        // 0xA5 odd parity (1), two stop bits, then 0x3C (odd parity 1) back-to-back
        fork
            begin
                send(1, 8'hA5, 1'b1);
                send(1, 8'h3C, 1'b0);
            end
            begin
                check_frame(1, "oddA5", 8'hA5, 1'b1, 1'b1, 2, 1'b1, 1'b1, 1);
                check_frame(1, "odd3C", 8'h3C, 1'b1, 1'b1, 2, 1'b0, 1'b0, 0);
            end
        join
        next_tick();

        // No parity: stop bit follows bit 7 directly
        fork
            send(2, 8'hA5, 1'b0);
            check_frame(2, "noneA5", 8'hA5, 1'b0, 1'b0, 1, 1'b1, 1'b0, 1);
        join
        next_tick();

        // 0x01 then 0x80 with data_valid held high; both have parity 1
        fork
            begin
                send(0, 8'h01, 1'b1);
                send(0, 8'h80, 1'b0);
                check_val("b2b_ready_after_accept", 32'(ready_v[0]), 32'd0);
                repeat (150) next_tick();
                check_val("b2b_ready_mid_frame", 32'(ready_v[0]), 32'd0);
            end
            begin
                check_frame(0, "b2b01", 8'h01, 1'b1, 1'b1, 1, 1'b1, 1'b1, 1);
                check_frame(0, "b2b80", 8'h80, 1'b1, 1'b1, 1, 1'b0, 1'b0, 0);
            end
        join
        next_tick();

        // Word offered while the holding register is full must be ignored
        fork
            begin
                send(0, 8'h0F, 1'b0);
                send(0, 8'h11, 1'b0);
                data_in = 8'hFF;
                dv[0] = 1'b1;
                @(posedge clk);
                @(negedge clk);
                #1;
                dv[0] = 1'b0;
                check_val("rej_ready", 32'(ready_v[0]), 32'd0);
            end
            begin
                check_frame(0, "rej0F", 8'h0F, 1'b1, 1'b0, 1, 1'b1, 1'b1, 1);
                check_frame(0, "rej11", 8'h11, 1'b1, 1'b0, 1, 1'b0, 1'b0, 0);
            end
        join
        next_tick();

        // Reset during data bit 3 of 0xA5 (bit 3 = 0) with a word waiting
        send(0, 8'hA5, 1'b0);
        n = 0;
        while (tx_v[0] !== 1'b0 && n < LIMIT) begin
            next_tick();
            n++;
        end
        check_val("mid_rst_start_timeout", 32'(n >= LIMIT), 32'd0);
        repeat (4 * OS + 8) next_tick();
        send(0, 8'h77, 1'b0);
        check_val("pre_rst_tx", 32'(tx_v[0]), 32'd0);
        check_val("pre_rst_ready", 32'(ready_v[0]), 32'd0);
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_tx", 32'(tx_v[0]), 32'd1);
        check_val("mid_rst_ready", 32'(ready_v[0]), 32'd1);
        check_val("mid_rst_busy", 32'(busy_v[0]), 32'd0);
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) next_tick();
        check_val("post_rst_idle_tx", 32'(tx_v[0]), 32'd1);

        // 0x3C even parity: 4 ones -> parity 0; held 0x77 must not follow
        fork
            send(0, 8'h3C, 1'b0);
            check_frame(0, "post3C", 8'h3C, 1'b1, 1'b0, 1, 1'b1, 1'b0, 1);
        join

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
